// File: rtl/hazard_scheduler_pkg.sv
// Shared pipeline types for the hazard scheduler: forward select encodings,
// shadow slot records and small helpers used by the top and fwd_sel.
package hazard_scheduler_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
  } slot_t;

  // Execute also remembers its sources so forwarding can be resolved there.
  typedef struct packed {
    slot_t            base;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } e_slot_t;

  // x0 is hard-wired to zero, so it never produces a hazard or a forward.
  function automatic logic is_writer(input logic             valid,
                                     input logic             regwrite,
                                     input logic [REG_W-1:0] rd);
    return valid && regwrite && (rd != '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/hazard_scheduler_fwd_sel.sv
// Operand forward select for one Execute source register: the most recent
// older writer (Memory before Writeback) supplies the value.
module fwd_sel
  import hazard_scheduler_pkg::*;
(
  input  logic             e_valid,
  input  logic [REG_W-1:0] rs,
  input  slot_t            m_slot,
  input  slot_t            w_slot,
  output fwd_sel_e         sel
);

  logic m_hit;
  logic w_hit;

  always_comb begin
    m_hit = is_writer(m_slot.valid, m_slot.regwrite, m_slot.rd) && (m_slot.rd == rs);
    w_hit = is_writer(w_slot.valid, w_slot.regwrite, w_slot.rd) && (w_slot.rd == rs);
    sel   = FWD_RF;
    if (e_valid) begin
      if (m_hit) begin
        sel = FWD_MEM;
      end else if (w_hit) begin
        sel = FWD_WB;
      end
    end
  end

  // The load flag does not influence source selection.
  logic unused_load_bits;
  assign unused_load_bits = m_slot.load ^ w_slot.load;

endmodule

// File: rtl/hazard_scheduler.sv
// Hazard detection and forwarding control for a five-stage in-order pipeline.
// A shadow copy of the E/M/W slots is rebuilt every cycle from the Decode fields.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             regwrite_d,
  input  logic             load_d,
  input  logic             pcsrc_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  e_slot_t          e_q, e_d;
  slot_t            m_q, m_d;
  slot_t            w_q, w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic     e_is_load_writer;
  logic     lu;
  logic     stall;
  logic     flush_e_raw;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  // Load-use: only the slot directly ahead (Execute) can be a load whose data
  // is not yet available when the Decode instruction reaches Execute.
  always_comb begin
    e_is_load_writer = is_writer(e_q.base.valid, e_q.base.regwrite, e_q.base.rd)
                       && e_q.base.load;
    lu = 1'b0;
    if (e_is_load_writer && valid_d) begin
      lu = (rs1_d == e_q.base.rd) || (rs2_d == e_q.base.rd);
    end
    // A taken branch discards Decode anyway, so it overrides the stall.
    stall       = lu && !pcsrc_e;
    flush_e_raw = lu || pcsrc_e;
  end

  always_comb begin
    e_d = '0;
    if (!flush_e_raw) begin
      e_d.base.valid    = valid_d;
      e_d.base.rd       = rd_d;
      e_d.base.regwrite = regwrite_d;
      e_d.base.load     = load_d;
      e_d.rs1           = rs1_d;
      e_d.rs2           = rs2_d;
    end
    m_d         = e_q.base;
    w_d         = m_q;
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, pcsrc_e);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q         <= '0;
      m_q         <= '0;
      w_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      w_q         <= w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .e_valid (e_q.base.valid),
    .rs      (e_q.rs1),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel     (fwd_a)
  );

  fwd_sel u_fwd_b (
    .e_valid (e_q.base.valid),
    .rs      (e_q.rs2),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel     (fwd_b)
  );

  // Reset holds every control output low even while pcsrc_e is driven.
  always_comb begin
    stall_f = stall && !rst;
    stall_d = stall && !rst;
    flush_d = pcsrc_e && !rst;
    flush_e = flush_e_raw && !rst;
    fwd_a_e = rst ? FWD_RF : fwd_a;
    fwd_b_e = rst ? FWD_RF : fwd_b;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Writeback only feeds forwarding; whether it was a load no longer matters.
  logic unused_w_load;
  assign unused_w_load = w_q.load;

  stall_implies_flush_e: assert property (@(posedge clk) disable iff (rst) stall_d |-> flush_e);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized and directed bench for hazard_scheduler with a scoreboard and an
// instruction-history reference model.
module tb_hazard_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_d, load_d, pcsrc_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [15:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .valid_d    (valid_d),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rd_d       (rd_d),
    .regwrite_d (regwrite_d),
    .load_d     (load_d),
    .pcsrc_e    (pcsrc_e),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // ---------------- reference model ----------------
  // hist[0] is the instruction now in Execute, hist[1] Memory, hist[2] Writeback.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
    bit [4:0] rs1;
    bit [4:0] rs2;
  } instr_t;

  instr_t      hist [3];
  bit   [15:0] m_stall_cnt;
  bit   [15:0] m_flush_cnt;

  logic [39:0] exp_q [$];
  string       tag_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          last_stall;

  function automatic bit writes_reg(instr_t i, bit [4:0] r);
    return i.v && i.rw && (i.rd != 5'd0) && (i.rd == r);
  endfunction

  // Youngest older instruction producing r supplies the value.
  function automatic bit [1:0] fwd_of(bit [4:0] r);
    if (!hist[0].v) return 2'b00;
    for (int age = 1; age <= 2; age++) begin
      if (writes_reg(hist[age], r)) return (age == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '{default: '0};
    m_stall_cnt = '0;
    m_flush_cnt = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit iv, input bit [4:0] is1, input bit [4:0] is2,
                             input bit [4:0] ird, input bit irw, input bit ild,
                             input bit ipc, input string tag, output bit stall);
    bit     lu, fe;
    instr_t nw;
    @(posedge clk);
    #1;
    valid_d    = iv;
    rs1_d      = is1;
    rs2_d      = is2;
    rd_d       = ird;
    regwrite_d = irw;
    load_d     = ild;
    pcsrc_e    = ipc;
    lu    = iv && hist[0].ld && (writes_reg(hist[0], is1) || writes_reg(hist[0], is2));
    stall = lu && !ipc;
    fe    = lu || ipc;
    exp_q.push_back({stall, stall, ipc, fe, fwd_of(hist[0].rs1), fwd_of(hist[0].rs2),
                     m_stall_cnt, m_flush_cnt});
    tag_q.push_back(tag);
    nw = '{v: iv, rd: ird, rw: irw, ld: ild, rs1: is1, rs2: is2};
    hist[2] = hist[1];
    hist[1] = hist[0];
    if (fe) hist[0] = '{default: '0};
    else    hist[0] = nw;
    if (stall && (m_stall_cnt != 16'hFFFF)) m_stall_cnt++;
    if (ipc && (m_flush_cnt != 16'hFFFF))   m_flush_cnt++;
  endtask

  task automatic instr(input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2,
                       input bit rw, input bit ld, input bit pc, input string tag);
    drive_cycle(1'b1, s1, s2, d, rw, ld, pc, tag, last_stall);
  endtask

  task automatic nop(input string tag);
    drive_cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, tag, last_stall);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic at_mid();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [39:0] e, a;
    string       t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, stall_cnt, flush_cnt};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", t, a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit       hold;
    bit       v, rw, ld, pc, st;
    bit [4:0] s1, s2, d;

    // Reset with a branch and a valid Decode driven: outputs must still read 0.
    rst = 1'b1; valid_d = 1'b1; rs1_d = 5'd3; rs2_d = 5'd4; rd_d = 5'd5;
    regwrite_d = 1'b1; load_d = 1'b1; pcsrc_e = 1'b1;
    model_reset();
    #12;
    chk("rst_stall_f", 16'(stall_f), 16'd0);
    chk("rst_stall_d", 16'(stall_d), 16'd0);
    chk("rst_flush_d", 16'(flush_d), 16'd0);
    chk("rst_flush_e", 16'(flush_e), 16'd0);
    chk("rst_fwd", 16'({fwd_a_e, fwd_b_e}), 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    valid_d = 1'b0; regwrite_d = 1'b0; load_d = 1'b0; pcsrc_e = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
    at_mid();
    rst = 1'b0;

    // Load-use: lw x5 ; add x6, x5, x7
    instr(5'd5, 5'd1, 5'd0, 1, 1, 0, "lu_lw");
    instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "lu_add");
    at_mid();
    chk("lu_stall_f", 16'(stall_f), 16'd1);
    chk("lu_stall_d", 16'(stall_d), 16'd1);
    chk("lu_flush_e", 16'(flush_e), 16'd1);
    instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "lu_add_held");
    at_mid();
    chk("lu_no_second_stall", 16'(stall_d), 16'd0);
    nop("lu_fwd");
    at_mid();
    chk("lu_fwd_a_wb", 16'(fwd_a_e), 16'd1);
    repeat (3) nop("gap");

    // ALU back-to-back: add x3, x1, x2 ; sub x4, x3, x3
    instr(5'd3, 5'd1, 5'd2, 1, 0, 0, "alu_add");
    instr(5'd4, 5'd3, 5'd3, 1, 0, 0, "alu_sub");
    nop("alu_fwd");
    at_mid();
    chk("alu_fwd_a_mem", 16'(fwd_a_e), 16'd2);
    chk("alu_fwd_b_mem", 16'(fwd_b_e), 16'd2);
    repeat (3) nop("gap");

    // Branch taken in the same cycle as a load-use match.
    instr(5'd5, 5'd1, 5'd0, 1, 1, 0, "br_lw");
    instr(5'd6, 5'd5, 5'd7, 1, 0, 1, "br_add");
    at_mid();
    chk("br_stall_d", 16'(stall_d), 16'd0);
    chk("br_flush_d", 16'(flush_d), 16'd1);
    chk("br_flush_e", 16'(flush_e), 16'd1);
    nop("br_after");
    at_mid();
    chk("br_e_bubble_fwd_a", 16'(fwd_a_e), 16'd0);
    repeat (3) nop("gap");

    // x0 is never a hazard source: addi x0 ; add x1, x0, x0 ; lw x0 ; add x2, x0, x0
    instr(5'd0, 5'd0, 5'd0, 1, 0, 0, "x0_addi");
    instr(5'd1, 5'd0, 5'd0, 1, 0, 0, "x0_add");
    at_mid();
    chk("x0_no_stall", 16'(stall_d), 16'd0);
    instr(5'd0, 5'd0, 5'd0, 1, 1, 0, "x0_lw");
    at_mid();
    chk("x0_fwd", 16'({fwd_a_e, fwd_b_e}), 16'd0);
    instr(5'd2, 5'd0, 5'd0, 1, 0, 0, "x0_use_load");
    at_mid();
    chk("x0_load_no_stall", 16'(stall_d), 16'd0);
    repeat (3) nop("gap");

    // Randomized traffic; Decode is held while a stall is requested.
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v  = ($urandom_range(7, 0) != 0);
        s1 = 5'($urandom_range(7, 0));
        s2 = 5'($urandom_range(7, 0));
        d  = 5'($urandom_range(7, 0));
        ld = ($urandom_range(2, 0) == 0);
        rw = ld || ($urandom_range(3, 0) != 0);
      end
      pc = ($urandom_range(7, 0) == 0);
      drive_cycle(v, s1, s2, d, rw, ld, pc, "rand", st);
      hold = st;
    end
    repeat (3) nop("gap");

    // Saturation: preload the stall counter near the top, then add real stalls.
    nop("sat_pre");
    @(negedge clk);
    #2;
    force dut.stall_cnt_q = 16'hFFFD;
    m_stall_cnt = 16'hFFFD;
    nop("sat_forced");
    @(negedge clk);
    #2;
    release dut.stall_cnt_q;
    for (int k = 0; k < 3; k++) begin
      instr(5'd5, 5'd1, 5'd0, 1, 1, 0, "sat_lw");
      instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "sat_add");
      instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "sat_add_held");
    end
    at_mid();
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    repeat (3) nop("gap");

    // Reset asserted during a stall cycle.
    instr(5'd5, 5'd1, 5'd0, 1, 1, 0, "mr_lw");
    instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "mr_add");
    at_mid();
    chk("mr_stall_before", 16'(stall_d), 16'd1);
    rst = 1'b1;
    #1;
    chk("mr_stall_f", 16'(stall_f), 16'd0);
    chk("mr_stall_d", 16'(stall_d), 16'd0);
    chk("mr_flush_e", 16'(flush_e), 16'd0);
    chk("mr_stall_cnt", stall_cnt, 16'd0);
    chk("mr_flush_cnt", flush_cnt, 16'd0);
    model_reset();
    @(posedge clk);
    at_mid();
    rst = 1'b0;
    instr(5'd6, 5'd5, 5'd7, 1, 0, 0, "mr_first_after");
    at_mid();
    chk("mr_first_no_stall", 16'(stall_d), 16'd0);
    repeat (3) nop("tail");

    for (int k = 0; (k < 10) && (exp_q.size() > 0); k++) @(negedge clk);
    chk("drain_empty", 16'(exp_q.size()), 16'd0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
